weighted_rr_arbiter: RTL
========================

Name: weighted_rr_arbiter

Overview:
- Registered N-way arbiter and next-generation successor to the combinational fixed-priority arbiter.
- Runtime-selectable mode: fixed priority (lowest index wins) or weighted round-robin.
- Grant is held across a multi-cycle transaction until the grantee signals done.
- Each requester receives up to weight+1 consecutive transactions before priority rotates.
- Sits in front of shared resources (bus, memory port) that serve one requester per transaction.

Parameters:
- NumRequests, 4: number of requesters, ≥2.
- WeightWidth, 2: bits per requester weight; max burst is 2^WeightWidth transactions.
- IdWidth, $clog2(NumRequests): width of grant_id (derived, not overridden).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed priority, 1 = weighted round-robin; sampled only at arbitration points.
- request  input  NumRequests  level request per requester; held high until served.
- weights  input  NumRequests*WeightWidth  flat; slice i = weight of requester i; sampled when i wins.
- done  input  1  one-cycle pulse from current grantee, ending its transaction; ignored when no grant is active.
- grant  output  NumRequests  registered one-hot grant, or all-zero.
- grant_valid  output  1  high iff grant is non-zero.
- grant_id  output  IdWidth  index of current grantee; 0 when grant_valid is low.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - grant=0, grant_valid=0, grant_id=0.
  - State=IDLE, pointer=0, credits=0.
  - Reset dominates every other input in the same cycle; a transaction in flight is dropped silently.
- States: IDLE, BUSY.
- IDLE:
  - If any request bit is set, the winner is computed combinationally that cycle.
  - grant, grant_id and grant_valid take the winner on the next edge (1-cycle latency); state goes to BUSY.
  - credits is loaded with weights[winner].
- BUSY: grant is held stable until one of these events.
  - done=1: transaction ends.
    - If credits>0 and request[grantee] is still high (mode=1 only): same grantee is retained, credits decrements, grant stays high with no gap.
    - Otherwise re-arbitrate in the same cycle. The new winner (possibly a different requester) is granted on the next edge, back-to-back with no idle cycle. If no request is pending, go to IDLE and grant=0 next edge.
  - request[grantee] drops without done: treated as abort, same as done with credits exhausted.
- Winner selection:
  - mode=0: lowest-index set bit of request. Pointer and credits are ignored; weight is treated as 0, so every transaction re-arbitrates.
  - mode=1: first set bit at or above pointer, scanning upward with wrap-around from NumRequests-1 to 0. Implemented as masked pick, falling back to unmasked pick if the masked vector is empty.
- Pointer update: whenever a grantee is relinquished by re-arbitration (credits exhausted, abort, or a switch to another winner), pointer = (grantee+1) mod NumRequests. Wrap is explicit; NumRequests need not be a power of 2.
- Credit arithmetic: WeightWidth-bit unsigned, counts down only, never underflows. Weight 0 means exactly one transaction.
- mode change while BUSY: takes effect at the next arbitration point; the current grant is not disturbed.
- Simultaneous done and a new request: both handled in the same cycle per the rules above.
- Invariants:
  - grant is always $onehot0.
  - grant only changes on a done/abort/reset edge, or on the edge leaving IDLE.
- Assertions:
  - grant is $onehot0.
  - grant_valid == |grant.
  - No grant to a requester whose request was low in the arbitration cycle.

Decomposition:
- Package arb_pkg:
  - arb_state_e {IDLE, BUSY}.
  - arb_mode_e {MODE_FIXED=0, MODE_WRR=1}.
  - Helper function to extract weight slice i from the flat vector.
- Sub-module masked_priority_picker (combinational, parameter NumRequests):
  - Inputs: request, pointer, mode.
  - Outputs: one-hot winner, winner index, any-valid.
- Top module contains the FSM, pointer register, credit counter and output registers.

Test Plan:
- Reset: assert reset for 2 cycles with request=4'b1111 → grant=0, grant_valid=0, grant_id=0 throughout; first grant 4'b0001 appears exactly 1 cycle after reset deasserts.
- Fixed mode: mode=0, request=4'b1010 held, done every 3rd cycle → grant stays 4'b0010 every transaction; requester 3 is never granted (starvation is expected).
- WRR rotation: mode=1, all weights=0, request=4'b1111 held, done each cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles.
- Weighted burst: weights={3,0,0,1} (req3..req0), request=4'b1001 held, done each cycle → req0 granted 2 times, then req3 granted 4 times, then back to req0.
- Abort and wrap: mode=1, req2 granted, request drops to 4'b0001 without done → next edge grant=4'b0001, pointer=3; then request=4'b1001 → req3 wins at the next arbitration (wrap order).
- Mid-transaction reset: BUSY with grant=4'b0100, credits=2, reset pulsed → grant=0 next edge; after release with request=4'b0101, grant=4'b0001 (pointer back to 0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_WRR = 1'b1} arb_mode_e;

  localparam int MaxFlatW = 256;

  // Flat weight vectors are zero-extended to MaxFlatW by the caller.
  function automatic logic [31:0] weight_slice(input logic [MaxFlatW-1:0] flat,
                                               input int idx, input int ww);
    logic [MaxFlatW-1:0] sh;
    sh = flat >> (idx * ww);
    return sh[31:0] & ((32'd1 << ww) - 32'd1);
  endfunction

endpackage

// File: rtl/masked_priority_picker.sv
// Combinational winner selection: lowest index, or first at/above pointer with wrap.
module masked_priority_picker
  import arb_pkg::*;
#(
  parameter int NumRequests = 4,
  localparam int IdWidth = $clog2(NumRequests)
) (
  input  logic [NumRequests-1:0] request,
  input  logic [IdWidth-1:0]     pointer,
  input  arb_mode_e              mode,
  output logic [NumRequests-1:0] winner,
  output logic [IdWidth-1:0]     winner_id,
  output logic                   any_valid
);

  logic [NumRequests-1:0] mask;
  logic [NumRequests-1:0] masked;
  logic [NumRequests-1:0] pick_vec;
  logic                   found;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NumRequests; i++) begin
      mask[i] = (i >= int'(pointer));
    end
    masked = request & mask;
    // An empty masked vector means the scan wrapped past the top index.
    pick_vec = (mode == MODE_WRR && |masked) ? masked : request;

    winner    = '0;
    winner_id = '0;
    found     = 1'b0;
    for (int i = 0; i < NumRequests; i++) begin
      if (pick_vec[i] && !found) begin
        winner[i] = 1'b1;
        winner_id = IdWidth'(i);
        found     = 1'b1;
      end
    end
    any_valid = |request;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Registered N-way arbiter: fixed priority or weighted round-robin, grant held until done.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NumRequests = 4,
  parameter int WeightWidth = 2,
  localparam int IdWidth = $clog2(NumRequests)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mode,
  input  logic [NumRequests-1:0]             request,
  input  logic [NumRequests*WeightWidth-1:0] weights,
  input  logic                               done,
  output logic [NumRequests-1:0]             grant,
  output logic                               grant_valid,
  output logic [IdWidth-1:0]                 grant_id
);

  arb_state_e             state, state_d;
  arb_mode_e              mode_e;
  logic [IdWidth-1:0]     pointer, pointer_d, next_ptr, pick_ptr;
  logic [WeightWidth-1:0] credits, credits_d, credits_load;
  logic [NumRequests-1:0] grant_d, winner;
  logic [IdWidth-1:0]     grant_id_d, winner_id;
  logic                   any_valid, grantee_req;

  assign mode_e      = arb_mode_e'(mode);
  assign next_ptr    = (grant_id == IdWidth'(NumRequests - 1)) ? '0 : grant_id + 1'b1;
  // While busy the picker only matters on relinquish, when the pointer moves past the grantee.
  assign pick_ptr    = (state == BUSY) ? next_ptr : pointer;
  assign grantee_req = |(request & grant);
  assign grant_valid = |grant;

  masked_priority_picker #(.NumRequests(NumRequests)) u_picker (
    .request  (request),
    .pointer  (pick_ptr),
    .mode     (mode_e),
    .winner   (winner),
    .winner_id(winner_id),
    .any_valid(any_valid)
  );

  always_comb begin
    credits_load = '0;
    if (mode_e == MODE_WRR) begin
      credits_load = WeightWidth'(weight_slice(MaxFlatW'(weights), int'(winner_id), WeightWidth));
    end
  end

  always_comb begin
    state_d    = state;
    pointer_d  = pointer;
    credits_d  = credits;
    grant_d    = grant;
    grant_id_d = grant_id;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_d    = BUSY;
          grant_d    = winner;
          grant_id_d = winner_id;
          credits_d  = credits_load;
        end
      end
      BUSY: begin
        if (done || !grantee_req) begin
          if (done && grantee_req && mode_e == MODE_WRR && credits != '0) begin
            credits_d = credits - 1'b1;
          end else begin
            pointer_d = next_ptr;
            if (any_valid) begin
              grant_d    = winner;
              grant_id_d = winner_id;
              credits_d  = credits_load;
            end else begin
              state_d    = IDLE;
              grant_d    = '0;
              grant_id_d = '0;
              credits_d  = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pointer  <= '0;
      credits  <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_d;
      pointer  <= pointer_d;
      credits  <= credits_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
    end
  end

  a_onehot: assert property (@(posedge clk) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) grant_valid == (|grant));
  a_req:    assert property (@(posedge clk) disable iff (reset)
                             (grant_valid && grant != $past(grant)) |-> |(grant & $past(request)));

endmodule
